// File: rtl/alu_sequencer_if.sv
// Bundles the command, result and ALU-drive signals of the ALU sequencer.
// The slave modport is the sequencer's view. The master modport is the view of the environment around it.
interface alu_sequencer_if #(
    parameter int BitWidth = 8
);
    logic                cmdValid;
    logic                cmdReady;
    logic [3:0]          cmdOp;
    logic [BitWidth-1:0] cmdA;
    logic [BitWidth-1:0] cmdB;
    logic                cmdUseFlags;
    logic                flagsClr;

    logic                resValid;
    logic                resReady;
    logic [BitWidth-1:0] resY;
    logic [3:0]          flagsReg;
    logic                busy;

    logic [BitWidth-1:0] aluA;
    logic [BitWidth-1:0] aluB;
    logic [3:0]          aluFuncOp;
    logic [3:0]          aluIFlags;
    logic                aluOE;
    logic [BitWidth-1:0] aluY;
    logic [3:0]          aluOFlags;

    modport slave (
        input  cmdValid, cmdOp, cmdA, cmdB, cmdUseFlags, flagsClr,
        input  resReady, aluY, aluOFlags,
        output cmdReady, resValid, resY, flagsReg, busy,
        output aluA, aluB, aluFuncOp, aluIFlags, aluOE
    );

    modport master (
        output cmdValid, cmdOp, cmdA, cmdB, cmdUseFlags, flagsClr,
        output resReady, aluY, aluOFlags,
        input  cmdReady, resValid, resY, flagsReg, busy,
        input  aluA, aluB, aluFuncOp, aluIFlags, aluOE
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences a single command through an external ALU: latch, drive, capture, then hold the result.
// FlagsReg carries N,Z,V,C between commands so that later operations can chain on it.
module alu_sequencer #(
    parameter int BitWidth = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DRIVE   = 2'b01,
        CAPTURE = 2'b10,
        HOLD    = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [BitWidth-1:0] a_q, a_d;
    logic [BitWidth-1:0] b_q, b_d;
    logic                useFlags_q, useFlags_d;
    logic [BitWidth-1:0] resY_q, resY_d;
    logic [3:0]          flags_q, flags_d;

    logic                cmdReady;
    logic                resValid;
    logic                busy;
    logic                aluOE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            useFlags_q <= 1'b0;
            resY_q     <= '0;
            flags_q    <= '0;
        end else begin
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            useFlags_q <= useFlags_d;
            resY_q     <= resY_d;
            flags_q    <= flags_d;
        end
    end

    // A flags clear in IDLE happens on the same edge as an acceptance.
    // Because of this, the accepted command already sees cleared flags in DRIVE.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        useFlags_d = useFlags_q;
        resY_d     = resY_q;
        flags_d    = flags_q;
        case (state_q)
            IDLE: begin
                if (bus.flagsClr) begin
                    flags_d = '0;
                end
                if (bus.cmdValid) begin
                    op_d       = bus.cmdOp;
                    a_d        = bus.cmdA;
                    b_d        = bus.cmdB;
                    useFlags_d = bus.cmdUseFlags;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                resY_d  = bus.aluY;
                flags_d = bus.aluOFlags;
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.resReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // cmdReady is held low while reset is asserted, even though the state register already reads IDLE.
    always_comb begin
        cmdReady = 1'b0;
        resValid = 1'b0;
        busy     = 1'b1;
        aluOE    = 1'b0;
        case (state_q)
            IDLE: begin
                cmdReady = rst_n;
                busy     = 1'b0;
            end
            DRIVE,
            CAPTURE: begin
                aluOE = 1'b1;
            end
            HOLD: begin
                resValid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign bus.cmdReady  = cmdReady;
    assign bus.resValid  = resValid;
    assign bus.busy      = busy;
    assign bus.aluOE     = aluOE;
    assign bus.resY      = resY_q;
    assign bus.flagsReg  = flags_q;
    assign bus.aluA      = a_q;
    assign bus.aluB      = b_q;
    assign bus.aluFuncOp = op_q;
    assign bus.aluIFlags = useFlags_q ? flags_q : 4'b0000;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU and a transaction-level flags model.
// Directed scenarios are followed by randomized commands, hold lengths and flag clears.
module tb_alu_sequencer;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;
    logic [3:0] modelFlags = 4'b0000;

    alu_sequencer_if #(.BitWidth(W)) bus ();

    alu_sequencer #(.BitWidth(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU behaviour: 0 ADD, 1 ADC, 2 SUB, 3 AND, 4 OR, 5 XOR, others pass A.
    // The result is returned as {N,Z,V,C,Y}.
    function automatic logic [11:0] aluModel(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic [3:0] fin);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        s = 9'd0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd1: begin
                s = {1'b0, a} + {1'b0, b} + {8'd0, fin[0]};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd2: begin
                r = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            default: r = a;
        endcase
        return {r[7], (r == 8'd0), v, c, r};
    endfunction

    always_comb begin
        {bus.aluOFlags, bus.aluY} = aluModel(bus.aluFuncOp, bus.aluA, bus.aluB, bus.aluIFlags);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rstResY", 32'(bus.resY), 32'd0);
        checkOutput("rstFlags", 32'(bus.flagsReg), 32'd0);
        checkOutput("rstResValid", 32'(bus.resValid), 32'd0);
        checkOutput("rstAluOE", 32'(bus.aluOE), 32'd0);
        checkOutput("rstAluA", 32'(bus.aluA), 32'd0);
        checkOutput("rstAluB", 32'(bus.aluB), 32'd0);
        checkOutput("rstAluOp", 32'(bus.aluFuncOp), 32'd0);
        checkOutput("rstIFlags", 32'(bus.aluIFlags), 32'd0);
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    endtask

    task automatic idleCycle(input logic clr);
        bus.cmdValid = 1'b0;
        bus.flagsClr = clr;
        @(posedge clk);
        @(negedge clk);
        bus.flagsClr = 1'b0;
        if (clr) modelFlags = 4'b0000;
        checkOutput("idleFlags", 32'(bus.flagsReg), 32'(modelFlags));
        checkOutput("idleBusy", 32'(bus.busy), 32'd0);
        checkOutput("idleReady", 32'(bus.cmdReady), 32'd1);
    endtask

    // One full command. The task is entered at a falling edge while the sequencer is idle.
    // It returns at the falling edge of the first IDLE cycle after the result handshake.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic useFlags, input logic clrAtAccept, input int holdCycles);
        logic [11:0] res;
        logic [3:0]  iflags;
        logic [7:0]  expY;
        logic [3:0]  expF;
        checkOutput("acceptReady", 32'(bus.cmdReady), 32'd1);
        bus.cmdValid    = 1'b1;
        bus.cmdOp       = op;
        bus.cmdA        = a;
        bus.cmdB        = b;
        bus.cmdUseFlags = useFlags;
        bus.flagsClr    = clrAtAccept;
        bus.resReady    = 1'b0;
        if (clrAtAccept) modelFlags = 4'b0000;
        iflags = useFlags ? modelFlags : 4'b0000;
        res  = aluModel(op, a, b, iflags);
        expY = res[7:0];
        expF = res[11:8];
        @(posedge clk);
        @(negedge clk);
        checkOutput("driveOE", 32'(bus.aluOE), 32'd1);
        checkOutput("driveBusy", 32'(bus.busy), 32'd1);
        checkOutput("driveReady", 32'(bus.cmdReady), 32'd0);
        checkOutput("driveValid", 32'(bus.resValid), 32'd0);
        checkOutput("driveA", 32'(bus.aluA), 32'(a));
        checkOutput("driveB", 32'(bus.aluB), 32'(b));
        checkOutput("driveOp", 32'(bus.aluFuncOp), 32'(op));
        checkOutput("driveIFlags", 32'(bus.aluIFlags), 32'(iflags));
        bus.cmdA     = ~a;
        bus.cmdB     = ~b;
        bus.flagsClr = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        checkOutput("capOE", 32'(bus.aluOE), 32'd1);
        checkOutput("capValid", 32'(bus.resValid), 32'd0);
        checkOutput("capReady", 32'(bus.cmdReady), 32'd0);
        checkOutput("capA", 32'(bus.aluA), 32'(a));
        checkOutput("capIFlags", 32'(bus.aluIFlags), 32'(iflags));
        bus.flagsClr = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        checkOutput("holdValid", 32'(bus.resValid), 32'd1);
        checkOutput("holdResY", 32'(bus.resY), 32'(expY));
        checkOutput("holdFlags", 32'(bus.flagsReg), 32'(expF));
        checkOutput("holdOE", 32'(bus.aluOE), 32'd0);
        checkOutput("holdReady", 32'(bus.cmdReady), 32'd0);
        modelFlags = expF;
        for (int i = 0; i < holdCycles; i++) begin
            bus.flagsClr = (i % 2 == 0);
            bus.cmdA     = 8'($urandom);
            bus.cmdOp    = 4'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkOutput("waitValid", 32'(bus.resValid), 32'd1);
            checkOutput("waitResY", 32'(bus.resY), 32'(expY));
            checkOutput("waitFlags", 32'(bus.flagsReg), 32'(expF));
            checkOutput("waitReady", 32'(bus.cmdReady), 32'd0);
            checkOutput("waitA", 32'(bus.aluA), 32'(a));
            checkOutput("waitOp", 32'(bus.aluFuncOp), 32'(op));
        end
        bus.flagsClr = 1'b0;
        bus.resReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resReady = 1'b0;
        bus.cmdValid = 1'b0;
        checkOutput("doneValid", 32'(bus.resValid), 32'd0);
        checkOutput("doneBusy", 32'(bus.busy), 32'd0);
        checkOutput("doneReady", 32'(bus.cmdReady), 32'd1);
        checkOutput("doneResY", 32'(bus.resY), 32'(expY));
        checkOutput("doneFlags", 32'(bus.flagsReg), 32'(expF));
        checkOutput("doneA", 32'(bus.aluA), 32'(a));
    endtask

    initial begin
        logic [7:0] pendY;
        logic [3:0] pendF;
        logic [11:0] r;
        rst_n           = 1'b0;
        bus.cmdValid    = 1'b0;
        bus.cmdOp       = 4'd0;
        bus.cmdA        = 8'd0;
        bus.cmdB        = 8'd0;
        bus.cmdUseFlags = 1'b0;
        bus.flagsClr    = 1'b0;
        bus.resReady    = 1'b0;
        pendY           = 8'd0;
        pendF           = 4'd0;
        #1;
        checkResetValues();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("postRstReady", 32'(bus.cmdReady), 32'd1);

        applyStimulus(4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 0);
        checkOutput("addOvfY", 32'(bus.resY), 32'h80);
        checkOutput("addOvfFlags", 32'(bus.flagsReg), 32'b1010);
        applyStimulus(4'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        checkOutput("addCarryFlags", 32'(bus.flagsReg), 32'b0101);
        applyStimulus(4'd0, 8'h00, 8'h00, 1'b1, 1'b0, 10);
        checkOutput("addZeroFlags", 32'(bus.flagsReg), 32'b0100);
        applyStimulus(4'd3, 8'h0F, 8'h3C, 1'b1, 1'b1, 0);
        checkOutput("andY", 32'(bus.resY), 32'h0C);

        // Keep cmdValid and resReady high: a command should be accepted every fourth cycle.
        bus.resReady    = 1'b1;
        bus.cmdValid    = 1'b1;
        bus.cmdUseFlags = 1'b0;
        bus.cmdOp       = 4'd0;
        for (int i = 0; i < 24; i++) begin
            bus.cmdA = 8'(i * 37);
            bus.cmdB = 8'(i + 100);
            checkOutput("b2bReady", 32'(bus.cmdReady), (i % 4 == 0) ? 32'd1 : 32'd0);
            checkOutput("b2bBusy", 32'(bus.busy), (i % 4 == 0) ? 32'd0 : 32'd1);
            checkOutput("b2bValid", 32'(bus.resValid), (i % 4 == 3) ? 32'd1 : 32'd0);
            if (i % 4 == 0) begin
                r = aluModel(4'd0, bus.cmdA, bus.cmdB, 4'b0000);
                pendY = r[7:0];
                pendF = r[11:8];
            end
            if (i % 4 == 3) begin
                checkOutput("b2bResY", 32'(bus.resY), 32'(pendY));
                checkOutput("b2bFlags", 32'(bus.flagsReg), 32'(pendF));
                modelFlags = pendF;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.cmdValid = 1'b0;
        bus.resReady = 1'b0;

        // Reset applied while in CAPTURE must discard the command.
        applyStimulus(4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 0);
        bus.cmdValid    = 1'b1;
        bus.cmdOp       = 4'd0;
        bus.cmdA        = 8'hFF;
        bus.cmdB        = 8'h01;
        bus.cmdUseFlags = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmdValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("preRstOE", 32'(bus.aluOE), 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetValues();
        @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        modelFlags = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("abortValid", 32'(bus.resValid), 32'd0);
            checkOutput("abortFlags", 32'(bus.flagsReg), 32'd0);
            checkOutput("abortReady", 32'(bus.cmdReady), 32'd1);
        end

        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                idleCycle(($urandom_range(0, 2) == 0));
            end
            applyStimulus(4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: BitWidth, default 8, data width of operands and result.
REQ-002 Clock  in  1  single system clock; all state changes on rising edge.
REQ-003 Reset_N  in  1  asynchronous, active-low reset.
REQ-004 CmdValid  in  1  command request.
REQ-005 CmdReady  out  1  sequencer can accept a command.
REQ-006 CmdOp  in  4  ALU function code, passed unmodified to AluFuncOp.
REQ-007 CmdA, CmdB  in  BitWidth  operands.
REQ-008 CmdUseFlags  in  1  1 = feed FlagsReg to ALU IFlags; 0 = feed 4'b0000.
REQ-009 FlagsClr  in  1  synchronous clear of FlagsReg.
REQ-010 ResValid  out  1  result available.
REQ-011 ResReady  in  1  consumer accepts result.
REQ-012 ResY  out  BitWidth  captured ALU result.
REQ-013 FlagsReg  out  4  captured ALU flags, layout [3:0] = N,Z,V,C.
REQ-014 Busy  out  1  high whenever state is not IDLE.
REQ-015 AluA, AluB  out  BitWidth; AluFuncOp  out  4; AluIFlags  out  4; AluOE  out  1  drive the ALU.
REQ-016 AluY  in  BitWidth; AluOFlags  in  4  ALU outputs.

Function
REQ-017 FSM states: IDLE, DRIVE, CAPTURE, HOLD; any unencoded state SHALL return to IDLE on the next edge.
REQ-018 IDLE: CmdReady=1; on CmdValid&&CmdReady, latch CmdOp, CmdA, CmdB, CmdUseFlags and go to DRIVE.
REQ-019 DRIVE: AluOE=1, ALU inputs from latched command; unconditional transition to CAPTURE (one settle cycle).
REQ-020 CAPTURE: AluOE=1; at the edge, ResY<=AluY, FlagsReg<=AluOFlags; go to HOLD.
REQ-021 HOLD: ResValid=1, ResY/FlagsReg stable; on ResReady go to IDLE; otherwise stay indefinitely.
REQ-022 CmdReady SHALL be 0 in DRIVE, CAPTURE and HOLD; commands presented there are not consumed.
REQ-023 Latency: ResValid rises exactly 2 edges after the accepting edge; minimum command spacing 4 cycles with ResReady held 1.
REQ-024 AluA/AluB/AluFuncOp SHALL hold the last latched values in all states (no change except on acceptance); AluOE=0 in IDLE and HOLD.
REQ-025 AluIFlags = latched CmdUseFlags ? FlagsReg : 4'b0000, sampled from FlagsReg as it stands in DRIVE/CAPTURE.
REQ-026 FlagsReg persists across commands; only CAPTURE, FlagsClr or reset modify it.
REQ-027 FlagsClr acts only in IDLE; ignored in other states; FlagsClr coincident with acceptance clears FlagsReg, so that command sees 4'b0000.
REQ-028 ResValid=0 in IDLE, DRIVE, CAPTURE; ResY retains last captured value after handshake.

Reset
REQ-029 Reset_N low SHALL immediately force state IDLE and ResY=0, FlagsReg=0, ResValid=0, AluOE=0, AluA=AluB=0, AluFuncOp=0, latched CmdUseFlags=0, Busy=0; CmdReady=1 once Reset_N is high.
REQ-030 Reset asserted mid-operation (DRIVE/CAPTURE/HOLD) SHALL abort the command with no result delivered and no FlagsReg update.

Verification
REQ-031 ADD, A=0x7F, B=0x01, UseFlags=0, ResReady=1 -> ResValid 2 edges after accept, ResY=0x80, FlagsReg=4'b1010 (N,V).
REQ-032 ADD 0xFF+0x01, then second ADD 0x00+0x00 with UseFlags=1 -> first FlagsReg=4'b0101 (Z,C); AluIFlags=4'b0101 during second command's DRIVE/CAPTURE.
REQ-033 ResReady=0 for 10 cycles in HOLD while CmdValid=1 with new operands -> ResY/FlagsReg stable, CmdReady=0, new command accepted only on the first IDLE cycle after ResReady.
REQ-034 FlagsClr=1 in HOLD, then in IDLE together with CmdValid, UseFlags=1 -> FlagsReg unchanged by HOLD pulse; AluIFlags=4'b0000 for the accepted command.
REQ-035 Reset_N pulsed low during CAPTURE -> all outputs at reset values within the same cycle, ResValid never asserted, FlagsReg=0.
REQ-036 Back-to-back CmdValid held high, ResReady=1 -> accepts exactly every 4 cycles, Busy low only in IDLE cycles.
